// File: rtl/ram_io_sram_bridge.sv
// Bridge from the RAM_IO fabric tile to a 256x32 single-port SRAM macro (1-cycle read latency).
// Define RAM_IO_SRAM_BRIDGE_STATUS_EN to add the dropped-strobe counter and {drop_cnt, ptr} readback.
module ram_io_sram_bridge (
  input  logic        UserCLK,
  input  logic        reset,
  input  logic [15:0] fab_d,
  input  logic [7:0]  fab_a,
  input  logic [3:0]  fab_c,
  input  logic [3:0]  cfg,
  output logic [15:0] ram2fab_d,
  output logic        sram_csb,
  output logic        sram_web,
  output logic [3:0]  sram_wmask,
  output logic [7:0]  sram_addr,
  output logic [31:0] sram_din,
  input  logic [31:0] sram_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

  state_t      state_reg, state_next;
  logic [15:0] d_q;
  logic [7:0]  a_q;
  logic [3:0]  c_q;
  logic        s_qq;
  logic [7:0]  ptr_reg;
  logic        rd_half_reg;
  logic        is_rd_reg;
  logic [15:0] rd_data_reg;
  logic        strobe_edge;
  logic        launch;
  logic [7:0]  access_addr;
  logic [31:0] din_next;
  logic [3:0]  wmask_next;

  assign access_addr = c_q[3] ? ptr_reg : a_q;

  // Each fabric half-word is replicated onto both macro lanes; the mask picks the live one.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign din_next[gi*16 +: 16]  = d_q;
    assign wmask_next[gi*2 +: 2]  = {2{c_q[1] & ((gi == 1) ? c_q[2] : ~c_q[2])}};
  end

  always_comb begin
    strobe_edge = c_q[0] & ~s_qq;
    launch      = 1'b0;
    state_next  = state_reg;
    case (state_reg)
      IDLE: begin
        if (cfg[0] && (cfg[1] ? c_q[0] : strobe_edge)) begin
          launch     = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS:  state_next = WAIT;
      WAIT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge UserCLK) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge UserCLK) begin
    if (reset) begin
      d_q         <= '0;
      a_q         <= '0;
      c_q         <= '0;
      s_qq        <= 1'b0;
      ptr_reg     <= '0;
      rd_half_reg <= 1'b0;
      is_rd_reg   <= 1'b0;
      rd_data_reg <= '0;
      sram_csb    <= 1'b1;
      sram_web    <= 1'b1;
      sram_wmask  <= '0;
      sram_addr   <= '0;
      sram_din    <= '0;
    end else begin
      d_q  <= fab_d;
      a_q  <= fab_a;
      c_q  <= fab_c;
      s_qq <= c_q[0];
      if (launch) begin
        sram_csb    <= 1'b0;
        sram_web    <= ~c_q[1];
        sram_addr   <= access_addr;
        sram_din    <= din_next;
        sram_wmask  <= wmask_next;
        rd_half_reg <= c_q[2];
        is_rd_reg   <= ~c_q[1];
        ptr_reg     <= access_addr + 8'd1;
      end
      if (state_reg == ACCESS) begin
        sram_csb   <= 1'b1;
        sram_web   <= 1'b1;
        sram_wmask <= '0;
      end
      // Macro data is valid one cycle after the sampling edge, i.e. during WAIT.
      if (state_reg == WAIT && is_rd_reg)
        rd_data_reg <= rd_half_reg ? sram_dout[31:16] : sram_dout[15:0];
    end
  end

`ifdef RAM_IO_SRAM_BRIDGE_STATUS_EN
  logic [7:0] drop_cnt_reg;
  logic       drop_event;
  logic       unused_cfg;

  // Only a fresh rising edge counts, so a level strobe held through busy cycles is not a drop.
  assign drop_event = cfg[0] & (state_reg != IDLE) & strobe_edge;
  assign unused_cfg = cfg[3];

  always_ff @(posedge UserCLK) begin
    if (reset)
      drop_cnt_reg <= '0;
    else if (drop_event && drop_cnt_reg != 8'hFF)
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
  end

  assign ram2fab_d = cfg[2] ? {drop_cnt_reg, ptr_reg} : rd_data_reg;
`else
  logic unused_cfg;

  assign unused_cfg = ^cfg[3:2];
  assign ram2fab_d  = rd_data_reg;
`endif

endmodule
